// File: rtl/risc_memory_access.sv
// risc_memory_access: memory-access stage, req/ack data-memory port.
// Define RISC_MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES with no ack.
module risc_memory_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EX_VALID,
  input  logic [1:0]  MD_0,
  input  logic        RW_0,
  input  logic [4:0]  DA_0,
  input  logic        MW_0,
  input  logic [31:0] FUNC_IN,
  input  logic [31:0] WDATA_IN,
  input  logic        NXORV_IN,
  output logic        MEM_STALL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [1:0]  MD_1,
  output logic        RW_1,
  output logic [4:0]  DA_1,
  output logic [31:0] FUNC_OUT,
  output logic [31:0] DATA_OUT,
  output logic        NxorV,
  output logic        MEM_ERR
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        need_mem;
  logic        timeout;
  logic [1:0]  md_q;
  logic        rw_q;
  logic [4:0]  da_q;
  logic        nxv_q;

  assign need_mem = EX_VALID & (MW_0 | (MD_0 == 2'd1));

`ifdef RISC_MEM_TIMEOUT_EN
  logic [7:0] to_cnt;

  assign timeout = (state == ACCESS) & ~MEM_ACK &
                   (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      to_cnt  <= 8'd0;
      MEM_ERR <= 1'b0;
    end else begin
      MEM_ERR <= timeout;
      if (state != ACCESS)
        to_cnt <= 8'd0;
      else if (!MEM_ACK)
        to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  // Never true; the limit only matters in the timeout build.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign MEM_ERR = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    MEM_STALL = 1'b0;
    unique case (state)
      IDLE: begin
        MEM_STALL = need_mem;
        if (need_mem)
          state_nxt = ACCESS;
      end
      ACCESS: begin
        MEM_STALL = ~MEM_ACK & ~timeout;
        if (MEM_ACK | timeout)
          state_nxt = IDLE;
      end
    endcase
  end

  // MEM_ADDR and MEM_WE double as the captured FUNC_IN and MW_0.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= 32'd0;
      MEM_WDATA <= 32'd0;
      MD_1      <= 2'd0;
      RW_1      <= 1'b0;
      DA_1      <= 5'd0;
      FUNC_OUT  <= 32'd0;
      DATA_OUT  <= 32'd0;
      NxorV     <= 1'b0;
      md_q      <= 2'd0;
      rw_q      <= 1'b0;
      da_q      <= 5'd0;
      nxv_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (need_mem) begin
            md_q      <= MD_0;
            rw_q      <= RW_0;
            da_q      <= DA_0;
            nxv_q     <= NXORV_IN;
            MEM_REQ   <= 1'b1;
            MEM_WE    <= MW_0;
            MEM_ADDR  <= FUNC_IN;
            MEM_WDATA <= WDATA_IN;
            RW_1      <= 1'b0;
          end else begin
            MD_1     <= EX_VALID ? MD_0 : 2'd0;
            RW_1     <= EX_VALID & RW_0;
            DA_1     <= DA_0;
            FUNC_OUT <= FUNC_IN;
            NxorV    <= NXORV_IN;
          end
        end
        ACCESS: begin
          if (MEM_ACK) begin
            if (!MEM_WE && md_q == 2'd1)
              DATA_OUT <= MEM_RDATA;
            MD_1     <= md_q;
            RW_1     <= rw_q;
            DA_1     <= da_q;
            FUNC_OUT <= MEM_ADDR;
            NxorV    <= nxv_q;
            MEM_REQ  <= 1'b0;
          end else begin
            RW_1 <= 1'b0;
            if (timeout)
              MEM_REQ <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_memory_access.sv
// tb_risc_memory_access: random instruction stream against a
// transaction-level model of the memory-access stage.
module tb_risc_memory_access;

  localparam int TO = 4;
`ifdef RISC_MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EX_VALID;
  logic [1:0]  MD_0;
  logic        RW_0;
  logic [4:0]  DA_0;
  logic        MW_0;
  logic [31:0] FUNC_IN;
  logic [31:0] WDATA_IN;
  logic        NXORV_IN;
  logic        MEM_STALL;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [1:0]  MD_1;
  logic        RW_1;
  logic [4:0]  DA_1;
  logic [31:0] FUNC_OUT;
  logic [31:0] DATA_OUT;
  logic        NxorV;
  logic        MEM_ERR;

  risc_memory_access #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EX_VALID(EX_VALID),
    .MD_0(MD_0), .RW_0(RW_0), .DA_0(DA_0), .MW_0(MW_0),
    .FUNC_IN(FUNC_IN), .WDATA_IN(WDATA_IN), .NXORV_IN(NXORV_IN),
    .MEM_STALL(MEM_STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .MD_1(MD_1), .RW_1(RW_1), .DA_1(DA_1),
    .FUNC_OUT(FUNC_OUT), .DATA_OUT(DATA_OUT),
    .NxorV(NxorV), .MEM_ERR(MEM_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0]  e_md1;
  logic        e_rw1;
  logic [4:0]  e_da1;
  logic [31:0] e_func;
  logic [31:0] e_data;
  logic        e_nxv;
  logic        e_req;
  logic        e_we;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic        e_err;
  bit          ctl_known;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset;
    e_md1 = '0; e_rw1 = 0; e_da1 = '0; e_func = '0; e_data = '0;
    e_nxv = 0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    e_err = 0; ctl_known = 1;
  endtask

  task automatic check_outs(input string t);
    check({t, ":req"}, MEM_REQ, e_req);
    check({t, ":rw1"}, RW_1, e_rw1);
    check({t, ":data"}, DATA_OUT, e_data);
    check({t, ":err"}, MEM_ERR, e_err);
    if (ctl_known) begin
      check({t, ":md1"}, MD_1, e_md1);
      check({t, ":da1"}, DA_1, e_da1);
      check({t, ":func"}, FUNC_OUT, e_func);
      check({t, ":nxv"}, NxorV, e_nxv);
    end
    if (e_req) begin
      check({t, ":we"}, MEM_WE, e_we);
      check({t, ":addr"}, MEM_ADDR, e_addr);
      check({t, ":wdata"}, MEM_WDATA, e_wdata);
    end
  endtask

  task automatic scramble;
    EX_VALID = 1'($urandom); MD_0 = 2'($urandom); RW_0 = 1'($urandom);
    DA_0 = 5'($urandom); MW_0 = 1'($urandom); FUNC_IN = $urandom;
    WDATA_IN = $urandom; NXORV_IN = 1'($urandom);
  endtask

  // One instruction from execute; dly = ACCESS cycles before the ack.
  task automatic run_instr(input logic v, input logic [1:0] md,
                           input logic rw, input logic [4:0] da,
                           input logic mw, input logic [31:0] f,
                           input logic [31:0] wd, input logic nx,
                           input int dly, input logic stray,
                           input logic [31:0] rdata);
    bit mem, load, done, ack, to;
    logic [31:0] rd;
    EX_VALID = v; MD_0 = md; RW_0 = rw; DA_0 = da; MW_0 = mw;
    FUNC_IN = f; WDATA_IN = wd; NXORV_IN = nx;
    MEM_ACK = stray; MEM_RDATA = $urandom;
    mem = v && (mw || md == 2'd1);
    load = mem && !mw;
    #1 check("stall_idle", MEM_STALL, mem);
    tick;
    MEM_ACK = 0;
    e_err = 0;
    if (!mem) begin
      e_md1 = v ? md : 2'd0; e_rw1 = v & rw; e_da1 = da;
      e_func = f; e_nxv = nx; ctl_known = 1;
      check_outs("pass");
    end else begin
      e_rw1 = 0; e_req = 1; e_we = mw; e_addr = f; e_wdata = wd;
      ctl_known = 0;
      check_outs("acc");
      done = 0;
      for (int k = 0; k <= dly && !done; k++) begin
        scramble();
        ack = (k == dly);
        to = TO_EN && !ack && (k == TO - 1);
        rd = ack ? rdata : $urandom;
        MEM_ACK = ack; MEM_RDATA = rd;
        #1 check("stall_acc", MEM_STALL, !ack && !to);
        tick;
        MEM_ACK = 0;
        e_err = 0;
        if (ack) begin
          e_req = 0;
          if (load) e_data = rd;
          e_md1 = md; e_rw1 = rw; e_da1 = da; e_func = f; e_nxv = nx;
          ctl_known = 1; done = 1;
          check_outs("ack");
        end else if (to) begin
          e_req = 0; e_err = 1; e_rw1 = 0; done = 1;
          check_outs("abort");
          e_err = 0;
        end else begin
          check_outs("wait");
        end
      end
    end
  endtask

  initial begin
    RESET_N = 0; MEM_ACK = 0; MEM_RDATA = '0;
    scramble();
    model_reset();
    tick;
    check("rst_stall", MEM_STALL, EX_VALID && (MW_0 || MD_0 == 2'd1));
    check("rst_we", MEM_WE, 0);
    check("rst_addr", MEM_ADDR, 0);
    check("rst_wdata", MEM_WDATA, 0);
    check_outs("rst");
    scramble();
    tick;
    check_outs("rst2");
    RESET_N = 1;

    run_instr(1, 2'd0, 1, 5'd5, 0, 32'h1234, 32'h0, 0, 0, 0, 32'h0);
    run_instr(1, 2'd1, 1, 5'd7, 0, 32'h40, 32'h0, 1, 3, 0,
              32'hDEADBEEF);
    run_instr(1, 2'd0, 0, 5'd9, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 0,
              32'h0);
    run_instr(1, 2'd1, 1, 5'd3, 1, 32'h84, 32'h5A5A5A5A, 0, 1, 0,
              32'h11111111);
    run_instr(1, 2'd2, 1, 5'd4, 0, 32'h99, 32'h0, 1, 0, 1, 32'h0);
    run_instr(0, 2'd1, 1, 5'd6, 1, 32'h77, 32'h0, 1, 0, 1, 32'h0);

`ifdef RISC_MEM_TIMEOUT_EN
    run_instr(1, 2'd1, 1, 5'd8, 0, 32'hC0, 32'h0, 0, 10, 0, 32'h0);
    run_instr(1, 2'd0, 1, 5'd2, 0, 32'h5555, 32'h0, 1, 0, 0, 32'h0);
    run_instr(1, 2'd1, 1, 5'd8, 0, 32'hC4, 32'h0, 0, TO - 1, 0,
              32'hFACEFEED);
`endif

    for (int i = 0; i < 300; i++) begin
      run_instr(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)),
                1'($urandom), 5'($urandom),
                ($urandom_range(0, 2) == 0), $urandom, $urandom,
                1'($urandom), $urandom_range(0, 6),
                1'($urandom), $urandom);
    end

    EX_VALID = 1; MD_0 = 2'd1; RW_0 = 1; DA_0 = 5'd1; MW_0 = 0;
    FUNC_IN = 32'h100; WDATA_IN = 32'h0; NXORV_IN = 0;
    tick;
    check("mid_req", MEM_REQ, 1);
    tick;
    RESET_N = 0;
    tick;
    model_reset();
    check_outs("mid_rst");
    RESET_N = 1;
    run_instr(0, 2'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    run_instr(0, 2'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 1, 32'hBAD);
    run_instr(0, 2'd0, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
